// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port synchronous data RAM between the CPU
// control unit and a second requester (display/DMA fetch).
//
// Each access uses a req/ack handshake and follows IDLE -> ACC -> RSP.
// The request is latched onto ram_* in IDLE or RSP. The RAM performs the
// access at the end of ACC. The ack pulses in RSP.
//
// Optional feature, selected by the macro ARB_ROUND_ROBIN_EN:
//   defined   - ties go to the port not granted last.
//   undefined - fixed CPU priority. DMA wins once after MAX_BURST
//               consecutive CPU grants made while dma_req is pending.
//
// Ports:
//   CLK, RST                 clock; synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata       1-cycle completion pulse; read data
//   cpu_stall                cpu_req & ~cpu_ack
//   dma_req/we/addr/wdata    second-port request, same rules
//   dma_ack, dma_rdata       1-cycle completion pulse; read data
//   ram_addr/din/we          registered RAM controls
//   ram_dout                 RAM read data, valid 1 cycle after address
module ram_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_RSP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                ram_we_q, ram_we_d;
    logic                gnt_dma_q, gnt_dma_d;   // owner of the access in flight
    logic                gnt_we_q, gnt_we_d;     // access in flight is a write
    logic                cpu_ack_q, cpu_ack_d;
    logic                dma_ack_q, dma_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic                last_dma_q, last_dma_d;
`else
    localparam logic [3:0] MAX_B = MAX_BURST[3:0];
    logic [3:0]          burst_q, burst_d;
`endif

    logic any_req;
    logic pick_dma;

    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_we_d    = 1'b0;
        gnt_dma_d   = gnt_dma_q;
        gnt_we_d    = gnt_we_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_dma_d  = last_dma_q;
        pick_dma    = dma_req & (~cpu_req | ~last_dma_q);
`else
        burst_d     = burst_q;
        pick_dma    = dma_req & (~cpu_req | (burst_q == MAX_B));
`endif
        any_req = cpu_req | dma_req;

        case (state_q)
            S_ACC: begin
                state_d   = S_RSP;
                cpu_ack_d = ~gnt_dma_q;
                dma_ack_d = gnt_dma_q;
            end
            S_IDLE, S_RSP: begin
                if (state_q == S_RSP && !gnt_we_q) begin
                    if (gnt_dma_q) dma_rdata_d = ram_dout;
                    else           cpu_rdata_d = ram_dout;
                end
                // A request still high during its own ack cycle is treated
                // as the next access. This gives back-to-back service to a
                // requester that keeps req asserted. A requester finishes by
                // dropping req in the ack cycle; ack is registered, so it can
                // safely derive that drop combinationally.
                if (any_req) begin
                    state_d    = S_ACC;
                    gnt_dma_d  = pick_dma;
                    gnt_we_d   = pick_dma ? dma_we : cpu_we;
                    ram_we_d   = pick_dma ? dma_we : cpu_we;
                    ram_addr_d = pick_dma ? dma_addr : cpu_addr;
                    ram_din_d  = pick_dma ? dma_wdata : cpu_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    last_dma_d = pick_dma;
`else
                    if (pick_dma)
                        burst_d = '0;
                    else if (dma_req && burst_q != MAX_B)
                        burst_d = burst_q + 4'd1;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifndef ARB_ROUND_ROBIN_EN
        if (!dma_req) burst_d = '0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_we_q    <= 1'b0;
            gnt_dma_q   <= 1'b0;
            gnt_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dma_q  <= 1'b1;
`else
            burst_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_we_q    <= ram_we_d;
            gnt_dma_q   <= gnt_dma_d;
            gnt_we_q    <= gnt_we_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_dma_q  <= last_dma_d;
`else
            burst_q     <= burst_d;
`endif
        end
    end

    // Reset during RSP suppresses the ack that is already registered.
    assign cpu_ack   = cpu_ack_q & ~RST;
    assign dma_ack   = dma_ack_q & ~RST;
    assign cpu_stall = cpu_req & ~cpu_ack;

    // Read data from the synchronous RAM only arrives in the ack cycle.
    // It is forwarded then, and the captured copy holds it afterwards.
    assign cpu_rdata = (cpu_ack & ~gnt_we_q) ? ram_dout : cpu_rdata_q;
    assign dma_rdata = (dma_ack & ~gnt_we_q) ? ram_dout : dma_rdata_q;

    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_we   = ram_we_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_ack, cpu_stall, dma_ack, ram_we;
    logic [15:0] cpu_rdata, dma_rdata, ram_addr, ram_din;
    logic [15:0] ram_dout;

    logic        pre_we;
    logic [15:0] pre_addr, pre_data;
    logic [15:0] mem [0:65535];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(4)) dut (
        .CLK(clk), .RST(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    // Synchronous single-port RAM model with a bench-only preload port.
    always @(posedge clk) begin
        if (pre_we)      mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic        rst, c_req, c_we;
        logic [15:0] c_addr, c_wd;
        logic        d_req, d_we;
        logic [15:0] d_addr, d_wd;
        logic        e_cack, e_dack, e_stall, e_we;
        logic [15:0] e_addr, e_crd, e_drd;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic r, cq, cw, input logic [15:0] ca, cd,
                                input logic dq, dw, input logic [15:0] da, dd,
                                input logic eca, eda, est, ewe,
                                input logic [15:0] ead, ecr, edr);
        vec_t v;
        v.rst = r; v.c_req = cq; v.c_we = cw; v.c_addr = ca; v.c_wd = cd;
        v.d_req = dq; v.d_we = dw; v.d_addr = da; v.d_wd = dd;
        v.e_cack = eca; v.e_dack = eda; v.e_stall = est; v.e_we = ewe;
        v.e_addr = ead; v.e_crd = ecr; v.e_drd = edr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic exp_d;

        rst = 1; idle_inputs();
        pre_we = 1; pre_addr = 16'h0400; pre_data = 16'hBEEF;
        tick(); pre_addr = 16'h0100; pre_data = 16'h1111;
        tick(); pre_addr = 16'h0200; pre_data = 16'h2222;
        tick(); pre_we = 0;

        // reset, CPU read latency/stall, CPU write + DMA read collision
        tbl[0]  = mk(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0, 16'h0000,16'h0000,16'h0000);
        tbl[1]  = mk(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0, 16'h0000,16'h0000,16'h0000);
        tbl[2]  = mk(0, 1,0,16'h0400,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,0, 16'h0000,16'h0000,16'h0000);
        tbl[3]  = mk(0, 1,0,16'h0400,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,0, 16'h0400,16'h0000,16'h0000);
        tbl[4]  = mk(0, 0,0,16'h0400,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,0, 16'h0400,16'hBEEF,16'h0000);
        tbl[5]  = mk(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0, 16'h0400,16'hBEEF,16'h0000);
        tbl[6]  = mk(0, 1,1,16'h0010,16'h1234, 1,0,16'h0010,16'h0000, 0,0,1,0, 16'h0400,16'hBEEF,16'h0000);
        tbl[7]  = mk(0, 1,1,16'h0010,16'h1234, 1,0,16'h0010,16'h0000, 0,0,1,1, 16'h0010,16'hBEEF,16'h0000);
        tbl[8]  = mk(0, 0,0,16'h0000,16'h0000, 1,0,16'h0010,16'h0000, 1,0,0,0, 16'h0010,16'hBEEF,16'h0000);
        tbl[9]  = mk(0, 0,0,16'h0000,16'h0000, 1,0,16'h0010,16'h0000, 0,0,0,0, 16'h0010,16'hBEEF,16'h0000);
        tbl[10] = mk(0, 0,0,16'h0000,16'h0000, 0,0,16'h0010,16'h0000, 0,1,0,0, 16'h0010,16'hBEEF,16'h1234);
        tbl[11] = mk(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0, 16'h0010,16'hBEEF,16'h1234);

        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst;
            cpu_req = tbl[i].c_req; cpu_we = tbl[i].c_we;
            cpu_addr = tbl[i].c_addr; cpu_wdata = tbl[i].c_wd;
            dma_req = tbl[i].d_req; dma_we = tbl[i].d_we;
            dma_addr = tbl[i].d_addr; dma_wdata = tbl[i].d_wd;
            #2;
            chk($sformatf("row%0d cpu_ack", i),   cpu_ack,   tbl[i].e_cack);
            chk($sformatf("row%0d dma_ack", i),   dma_ack,   tbl[i].e_dack);
            chk($sformatf("row%0d cpu_stall", i), cpu_stall, tbl[i].e_stall);
            chk($sformatf("row%0d ram_we", i),    ram_we,    tbl[i].e_we);
            chk($sformatf("row%0d ram_addr", i),  ram_addr,  tbl[i].e_addr);
            chk($sformatf("row%0d cpu_rdata", i), cpu_rdata, tbl[i].e_crd);
            chk($sformatf("row%0d dma_rdata", i), dma_rdata, tbl[i].e_drd);
            tick();
        end

        // Starvation cap: both held -> C,C,C,C,D repeating, one access per 2 cycles.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
        dma_req = 1; dma_we = 0; dma_addr = 16'h0200;
        #2;
        for (int k = 0; k < 10; k++) begin
            n = 0;
            while (!(cpu_ack | dma_ack) && n < 6) begin
                @(posedge clk); #3; n++;
            end
            if (!(cpu_ack | dma_ack)) begin
                chk($sformatf("t4 ack%0d timeout", k), 32'd0, 32'd1);
                break;
            end
            exp_d = (k % 5 == 4);
            chk($sformatf("t4 grant%0d is_dma", k), dma_ack, exp_d);
            chk($sformatf("t4 grant%0d gap", k), n, (k == 0) ? 2 : 1);
            if (exp_d) chk($sformatf("t4 grant%0d dma_rdata", k), dma_rdata, 16'h2222);
            else       chk($sformatf("t4 grant%0d cpu_rdata", k), cpu_rdata, 16'h1111);
            if (k == 9) begin cpu_req = 0; dma_req = 0; end
            @(posedge clk); #3;
        end
        idle_inputs();
        tick(); tick();

        // Back-to-back CPU reads, no idle gaps: acks at +2, +4, +6.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0400;
        for (int c = 0; c < 8; c++) begin
            #2;
            chk($sformatf("t5 c%0d cpu_ack", c), cpu_ack, (c == 2 || c == 4 || c == 6));
            chk($sformatf("t5 c%0d cpu_stall", c), cpu_stall,
                (c <= 6) && !(c == 2 || c == 4 || c == 6));
            if (c == 2 || c == 4 || c == 6)
                chk($sformatf("t5 c%0d cpu_rdata", c), cpu_rdata, 16'hBEEF);
            if (c == 6) cpu_req = 0;
            tick();
        end
        idle_inputs();
        tick();

        // Reset in ACC of a DMA write: write lands, no ack, back to IDLE.
        dma_req = 1; dma_we = 1; dma_addr = 16'h0020; dma_wdata = 16'hAAAA;
        tick();
        rst = 1;
        #2;
        chk("t6 acc ram_we", ram_we, 1'b1);
        chk("t6 acc ram_din", ram_din, 16'hAAAA);
        tick();
        rst = 0; dma_req = 0; dma_we = 0;
        #2;
        chk("t6 c2 dma_ack", dma_ack, 1'b0);
        chk("t6 c2 ram_we", ram_we, 1'b0);
        tick();
        chk("t6 c3 dma_ack", dma_ack, 1'b0);
        chk("t6 ram contents", mem[16'h0020], 16'hAAAA);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
        tick();
        #2;
        chk("t6 readback early ack", cpu_ack, 1'b0);
        tick();
        #2;
        chk("t6 readback ack", cpu_ack, 1'b1);
        chk("t6 readback data", cpu_rdata, 16'hAAAA);
        cpu_req = 0;
        tick();

        // Reset in RSP of a CPU read: ack suppressed, rdata cleared.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
        tick();
        tick();
        rst = 1; cpu_req = 0;
        #2;
        chk("t7 rsp cpu_ack", cpu_ack, 1'b0);
        tick();
        rst = 0;
        #2;
        chk("t7 cpu_rdata cleared", cpu_rdata, 16'h0000);
        chk("t7 post cpu_ack", cpu_ack, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
